// File: rtl/alu_pkg.sv
// alu_pkg: opcodes and FSM state encoding shared by the ALU and the ALU control decoder
package alu_pkg;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_DIV = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_e;
endpackage

// File: rtl/alu_multicycle_if.sv
// alu_multicycle_if: request/result bus between the EX stage and alu_multicycle
interface alu_multicycle_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic [2:0]       ALUCtrl_i;
  logic             valid_o;
  logic [WIDTH-1:0] data_o;
  logic             zero_o;
  logic             busy_o;
  modport slave (
    input  valid_i, data1_i, data2_i, ALUCtrl_i,
    output ready_o, valid_o, data_o, zero_o, busy_o
  );
  modport master (
    output valid_i, data1_i, data2_i, ALUCtrl_i,
    input  ready_o, valid_o, data_o, zero_o, busy_o
  );
endinterface

// File: rtl/alu_iter_unit.sv
// alu_iter_unit: shift-add multiplier, plus restoring divider under ALU_MULTICYCLE_DIV_EN
module alu_iter_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  logic             run_q, done_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
`ifdef ALU_MULTICYCLE_DIV_EN
  logic         op_q;
  logic [WIDTH:0] trial;
  // For DIV: acc_q is the remainder, mplier_q shifts the dividend out and the quotient in
  assign trial = {acc_q, mplier_q[WIDTH-1]} - {1'b0, mcand_q};
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) op_q <= 1'b0;
    else if (start_i) op_q <= op_i;
  assign result_o = op_q ? mplier_q : acc_q;
`else
  assign result_o = op_i ? '0 : acc_q;
`endif
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      run_q    <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start_i) begin
      run_q    <= 1'b1;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= b_i;
      mplier_q <= a_i;
    end else if (run_q) begin
`ifdef ALU_MULTICYCLE_DIV_EN
      if (op_q) begin
        acc_q    <= trial[WIDTH] ? {acc_q[WIDTH-2:0], mplier_q[WIDTH-1]} : trial[WIDTH-1:0];
        mplier_q <= {mplier_q[WIDTH-2:0], ~trial[WIDTH]};
      end else
`endif
      begin
        acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
      end
      cnt_q  <= cnt_q + CNT_W'(1);
      run_q  <= cnt_q != LAST;
      done_q <= cnt_q == LAST;
    end else begin
      done_q <= 1'b0;
    end
  assign done_o = done_q;
endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: registered ALU, 1-cycle logic/arith ops, iterative MUL (DIV with ALU_MULTICYCLE_DIV_EN)
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic             clk_i,
  input logic             rst_i,
  alu_multicycle_if.slave bus
);
  state_e           state_q;
  logic [WIDTH-1:0] data_q, res_d, iter_res;
  logic             zero_q, valid_q, is_mul, is_div, iter_op, accept, start, done;
  logic [2:0]       op;
  logic             slt;
  assign op = bus.ALUCtrl_i;
  assign is_mul = op == ALU_MUL;
`ifdef ALU_MULTICYCLE_DIV_EN
  assign is_div = op == ALU_DIV;
`else
  assign is_div = 1'b0;
`endif
  assign iter_op = is_mul | is_div;
  assign accept = state_q == ST_IDLE && bus.valid_i;
  assign start = accept && iter_op;
  assign slt = $signed(bus.data1_i) < $signed(bus.data2_i);
  assign res_d = op == ALU_AND ? bus.data1_i & bus.data2_i :
                 op == ALU_OR  ? bus.data1_i | bus.data2_i :
                 op == ALU_ADD ? bus.data1_i + bus.data2_i :
                 op == ALU_SUB ? bus.data1_i - bus.data2_i :
                 op == ALU_SLT ? {{(WIDTH-1){1'b0}}, slt} : '0;
  alu_iter_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start),
    .op_i    (is_div),
    .a_i     (bus.data1_i),
    .b_i     (bus.data2_i),
    .done_o  (done),
    .result_o(iter_res)
  );
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      zero_q  <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (accept && iter_op) begin
        state_q <= is_div ? ST_DIV : ST_MUL;
      end else if (accept) begin
        data_q  <= res_d;
        zero_q  <= ~|res_d;
        valid_q <= 1'b1;
      end else if (state_q != ST_IDLE && done) begin
        state_q <= ST_IDLE;
        data_q  <= iter_res;
        zero_q  <= ~|iter_res;
        valid_q <= 1'b1;
      end
    end
  assign bus.ready_o = state_q == ST_IDLE;
  // Busy drops once the last iteration has landed, one cycle before the result is registered
  assign bus.busy_o  = state_q != ST_IDLE && !done;
  assign bus.valid_o = valid_q;
  assign bus.data_o  = data_q;
  assign bus.zero_o  = zero_q;
endmodule
